// File: rtl/acc_cpu_pkg.sv
// Shared constants for the accumulator CPU: default widths, register count
// and ALU operation codes.
package acc_cpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PC_W   = 8;
    localparam int REG_COUNT  = 16;
    localparam int REG_IDX_W  = 4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b1000;
    localparam logic [3:0] ALU_SHR = 4'b1100;
    localparam logic [3:0] ALU_SHL = 4'b1101;

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU: ACC op B, DATA_W+1 bit result whose top bit is the carry.
module acc_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        sel_alu,
    output logic [DATA_W:0]   result
);

    // Operation decode; the subtract borrow falls out of the widened wrap.
    always_comb begin
        result = {1'b0, acc};
        case (sel_alu)
            ALU_ADD: result = {1'b0, acc} + {1'b0, b};
            ALU_SUB: result = {1'b0, acc} - {1'b0, b};
            ALU_NOR: result = {1'b0, ~(acc | b)};
            ALU_SHR: result = {acc[0], 1'b0, acc[DATA_W-1:1]};
            ALU_SHL: result = {acc[DATA_W-1], acc[DATA_W-2:0], 1'b0};
            default: result = {1'b0, acc};
        endcase
    end

endmodule

// File: rtl/acc_datapath.sv
// Accumulator CPU datapath: PC, IR, 16-entry register file, ACC with carry.
// Build option ACC_ZERO_FLAG_EN folds "ACC non-zero" into Zero_Carry.
module acc_datapath
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_W   = DEF_PC_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 LoadIR,
    input  logic                 IncPC,
    input  logic                 SelPC,
    input  logic                 LoadPC,
    input  logic                 LoadReg,
    input  logic                 DumpReg,
    input  logic                 LoadAcc,
    input  logic                 DumpAcc,
    input  logic                 SelAcc0,
    input  logic                 SelAcc1,
    input  logic [3:0]           SelALU,
    input  logic [3:0]           ImmediateData,
    input  logic [3:0]           RegNumber,
    input  logic [DATA_W-1:0]    InstrData,
    output logic [PC_W-1:0]      InstrAddr,
    output logic [DATA_W-1:0]    Opcode,
    output logic                 Zero_Carry,
    output logic [DATA_W-1:0]    AccOut
);

    logic [PC_W-1:0]   pc_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W:0]   acc_r;
    logic [DATA_W-1:0] regs_r [REG_COUNT];

    logic [DATA_W-1:0] b_bus_s;
    logic [DATA_W-1:0] imm_ext_s;
    logic [DATA_W:0]   alu_result_s;
    logic [DATA_W:0]   acc_next_s;
    logic [PC_W-1:0]   pc_jump_s;

    assign imm_ext_s = DATA_W'(ImmediateData);

    // B bus and jump source; jumps always index the register file through IR.
    always_comb begin
        if (DumpReg) begin
            b_bus_s = regs_r[RegNumber];
        end else begin
            b_bus_s = {DATA_W{1'b0}};
        end
        if (SelPC) begin
            pc_jump_s = PC_W'(ir_r[3:0]);
        end else begin
            pc_jump_s = PC_W'(regs_r[ir_r[3:0]]);
        end
    end

    acc_alu #(.DATA_W(DATA_W)) u_alu (
        .acc     (acc_r[DATA_W-1:0]),
        .b       (b_bus_s),
        .sel_alu (SelALU),
        .result  (alu_result_s)
    );

    // ACC source select; only the ALU path may leave carry set.
    always_comb begin
        case ({SelAcc1, SelAcc0})
            2'b10, 2'b11: acc_next_s = alu_result_s;
            2'b01:        acc_next_s = {1'b0, b_bus_s};
            2'b00:        acc_next_s = {1'b0, imm_ext_s};
            default:      acc_next_s = {(DATA_W+1){1'b0}};
        endcase
    end

    // PC, IR and ACC state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r  <= {PC_W{1'b0}};
            ir_r  <= {DATA_W{1'b0}};
            acc_r <= {(DATA_W+1){1'b0}};
        end else begin
            if (LoadPC) begin
                pc_r <= pc_jump_s;
            end else if (IncPC) begin
                pc_r <= pc_r + PC_W'(1'b1);
            end
            if (LoadIR) begin
                ir_r <= InstrData;
            end
            if (LoadAcc) begin
                acc_r <= acc_next_s;
            end
        end
    end

    // Register file write port; DumpAcc stores the pre-edge ACC value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (DumpAcc) begin
            regs_r[RegNumber] <= acc_r[DATA_W-1:0];
        end else if (LoadReg) begin
            regs_r[RegNumber] <= imm_ext_s;
        end
    end

    assign InstrAddr = pc_r;
    assign Opcode    = ir_r;
    assign AccOut    = acc_r[DATA_W-1:0];

`ifdef ACC_ZERO_FLAG_EN
    assign Zero_Carry = acc_r[DATA_W] | (acc_r[DATA_W-1:0] != {DATA_W{1'b0}});
`else
    assign Zero_Carry = acc_r[DATA_W];
`endif

endmodule

// File: tb/tb_acc_datapath.sv
// Bench for acc_datapath: directed scenarios plus random strobes compared
// every cycle against an arithmetic model of the datapath.
module tb_acc_datapath;

    logic       clk = 1'b0;
    logic       reset, LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg;
    logic       LoadAcc, DumpAcc, SelAcc0, SelAcc1;
    logic [3:0] SelALU, ImmediateData, RegNumber;
    logic [7:0] InstrData;
    logic [7:0] InstrAddr, Opcode, AccOut;
    logic       Zero_Carry;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

`ifdef ACC_ZERO_FLAG_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    // model state
    int m_pc, m_ir, m_acc, m_carry;
    int m_regs [16];

    acc_datapath dut (
        .clk(clk), .reset(reset), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
        .LoadPC(LoadPC), .LoadReg(LoadReg), .DumpReg(DumpReg), .LoadAcc(LoadAcc),
        .DumpAcc(DumpAcc), .SelAcc0(SelAcc0), .SelAcc1(SelAcc1), .SelALU(SelALU),
        .ImmediateData(ImmediateData), .RegNumber(RegNumber), .InstrData(InstrData),
        .InstrAddr(InstrAddr), .Opcode(Opcode), .Zero_Carry(Zero_Carry), .AccOut(AccOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_zc();
        if (ZF) return (m_carry != 0 || m_acc != 0) ? 1 : 0;
        return m_carry;
    endfunction

    // Applies the datapath rules to the inputs present at this edge.
    task automatic model_update();
        int b, res, car, nacc, ncar, npc;
        if (reset) begin
            m_pc = 0; m_ir = 0; m_acc = 0; m_carry = 0;
            for (int i = 0; i < 16; i++) m_regs[i] = 0;
            return;
        end
        b = DumpReg ? m_regs[RegNumber] : 0;
        case (SelALU)
            4'd0:  begin res = m_acc + b; car = (res > 255) ? 1 : 0; res = res % 256; end
            4'd1:  begin car = (m_acc < b) ? 1 : 0; res = (m_acc - b + 256) % 256; end
            4'd8:  begin res = 255 - (m_acc | b); car = 0; end
            4'd12: begin res = m_acc / 2; car = m_acc % 2; end
            4'd13: begin res = (m_acc * 2) % 256; car = m_acc / 128; end
            default: begin res = m_acc; car = 0; end
        endcase
        if (SelAcc1)      begin nacc = res; ncar = car; end
        else if (SelAcc0) begin nacc = b; ncar = 0; end
        else              begin nacc = ImmediateData; ncar = 0; end
        npc = m_pc;
        if (LoadPC) npc = SelPC ? (m_ir % 16) : m_regs[m_ir % 16];
        else if (IncPC) npc = (m_pc + 1) % 256;
        if (DumpAcc) m_regs[RegNumber] = m_acc;
        else if (LoadReg) m_regs[RegNumber] = ImmediateData;
        if (LoadAcc) begin m_acc = nacc; m_carry = ncar; end
        if (LoadIR) m_ir = InstrData;
        m_pc = npc;
    endtask

    task automatic clear_ctrl();
        reset = 1'b0; LoadIR = 1'b0; IncPC = 1'b0; SelPC = 1'b0; LoadPC = 1'b0;
        LoadReg = 1'b0; DumpReg = 1'b0; LoadAcc = 1'b0; DumpAcc = 1'b0;
        SelAcc0 = 1'b0; SelAcc1 = 1'b0; SelALU = 4'd0; ImmediateData = 4'd0;
        RegNumber = 4'd0; InstrData = 8'd0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk_en = 1'b1;
        clear_ctrl();
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_addr", int'(InstrAddr), m_pc);
            check("opcode", int'(Opcode), m_ir);
            check("acc_out", int'(AccOut), m_acc);
            check("zero_carry", int'(Zero_Carry), model_zc());
        end
    end

    logic [3:0] ops [5] = '{4'd0, 4'd1, 4'd8, 4'd12, 4'd13};

    initial begin
        clear_ctrl();
        reset = 1'b1; step();
        reset = 1'b1; step();
        check("rst_opcode", int'(Opcode), 0);
        check("rst_pc", int'(InstrAddr), 0);
        check("rst_acc", int'(AccOut), 0);
        check("rst_zc", int'(Zero_Carry), 0);

        InstrData = 8'h4A; LoadIR = 1'b1; step();
        check("ir_4a", int'(Opcode), 8'h4A);
        check("ir_pc", int'(InstrAddr), 0);

        ImmediateData = 4'hF; LoadAcc = 1'b1; step();
        check("imm_acc", int'(AccOut), 8'h0F);
        check("imm_zc", int'(Zero_Carry), int'(ZF));
        DumpAcc = 1'b1; RegNumber = 4'd3; step();
        LoadAcc = 1'b1; ImmediateData = 4'h0; step();
        DumpReg = 1'b1; RegNumber = 4'd3; SelAcc0 = 1'b1; LoadAcc = 1'b1; step();
        check("reg3_read", int'(AccOut), 8'h0F);

        // ACC=FF via NOR of 0 with 0, Reg1=1, then add
        LoadAcc = 1'b1; ImmediateData = 4'h0; step();
        LoadAcc = 1'b1; SelAcc1 = 1'b1; SelALU = 4'b1000; step();
        check("nor_ff", int'(AccOut), 8'hFF);
        LoadReg = 1'b1; RegNumber = 4'd1; ImmediateData = 4'h1; step();
        DumpReg = 1'b1; RegNumber = 4'd1; SelALU = 4'b0000; SelAcc1 = 1'b1; LoadAcc = 1'b1; step();
        check("add_wrap_acc", int'(AccOut), 8'h00);
        check("add_wrap_zc", int'(Zero_Carry), 1);

        reset = 1'b1; step();
        check("zero_zc", int'(Zero_Carry), 0);
        LoadAcc = 1'b1; ImmediateData = 4'h5; step();
        check("five_zc", int'(Zero_Carry), int'(ZF));

        // Reg12=FF, IR=7C; immediate jump beats increment, then reg jump, then wrap
        LoadAcc = 1'b1; SelAcc1 = 1'b1; SelALU = 4'b1000; ImmediateData = 4'h0; step();
        LoadAcc = 1'b1; ImmediateData = 4'h0; step();
        LoadAcc = 1'b1; SelAcc1 = 1'b1; SelALU = 4'b1000; step();
        DumpAcc = 1'b1; RegNumber = 4'd12; step();
        InstrData = 8'h7C; LoadIR = 1'b1; step();
        LoadPC = 1'b1; SelPC = 1'b1; IncPC = 1'b1; step();
        check("jump_imm", int'(InstrAddr), 8'h0C);
        LoadPC = 1'b1; SelPC = 1'b0; step();
        check("jump_reg", int'(InstrAddr), 8'hFF);
        IncPC = 1'b1; step();
        check("pc_wrap", int'(InstrAddr), 8'h00);

        reset = 1'b1; LoadAcc = 1'b1; DumpAcc = 1'b1; ImmediateData = 4'h9;
        IncPC = 1'b1; LoadIR = 1'b1; InstrData = 8'h33; step();
        check("rst_mid_acc", int'(AccOut), 0);
        check("rst_mid_pc", int'(InstrAddr), 0);
        check("rst_mid_ir", int'(Opcode), 0);
        check("rst_mid_zc", int'(Zero_Carry), 0);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 127) == 0);
            LoadIR = 1'($urandom); IncPC = 1'($urandom); SelPC = 1'($urandom);
            LoadPC = ($urandom_range(0, 7) == 0); LoadReg = 1'($urandom);
            DumpReg = 1'($urandom); LoadAcc = 1'($urandom); DumpAcc = ($urandom_range(0, 3) == 0);
            SelAcc0 = 1'($urandom); SelAcc1 = 1'($urandom);
            SelALU = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 4)] : 4'($urandom);
            ImmediateData = 4'($urandom); RegNumber = 4'($urandom); InstrData = 8'($urandom);
            step();
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_datapath.md
# acc_datapath

Datapath for the accumulator CPU: holds the program counter, instruction register, 16-entry register file, accumulator with carry extension and ALU. It sits opposite the Controller, consumes every control strobe the Controller drives, and returns `Opcode` and `Zero_Carry` to close the fetch/decode/execute loop. Instruction memory is external, with a combinational read addressed by `InstrAddr`.

## Interface
- `DATA_W`, 8, width of the accumulator, registers and instruction word
- `PC_W`, 8, program counter width
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `LoadIR` in 1: capture `InstrData` into IR
- `IncPC` in 1: PC <= PC+1
- `SelPC` in 1: jump source select; 1 = immediate IR[3:0], 0 = Reg[IR[3:0]]
- `LoadPC` in 1: load PC from the jump source
- `LoadReg` in 1: Reg[RegNumber] <= zero-extended `ImmediateData`
- `DumpReg` in 1: enable the register read port onto the B bus
- `LoadAcc` in 1: ACC write enable
- `DumpAcc` in 1: Reg[RegNumber] <= ACC[DATA_W-1:0]
- `SelAcc0` in 1: ACC source select, low bit
- `SelAcc1` in 1: ACC source select, high bit
- `SelALU` in 4: ALU operation
- `ImmediateData` in 4: immediate operand
- `RegNumber` in 4: register index
- `InstrData` in DATA_W: instruction memory read data
- `InstrAddr` out PC_W: equals PC, driven straight from the register
- `Opcode` out DATA_W: IR contents
- `Zero_Carry` out 1: status returned to the Controller
- `AccOut` out DATA_W: ACC[DATA_W-1:0], for observation

## Operation
- B bus = Reg[RegNumber] when `DumpReg`=1, else 0. Register file read is combinational.
- ACC source, applied when `LoadAcc`=1:
  - `SelAcc1`=1: ALU result, including carry bit.
  - `SelAcc1`=0, `SelAcc0`=1: B bus, carry cleared.
  - Both 0: zero-extended `ImmediateData`, carry cleared.
- ALU, ACC op B; all arithmetic is DATA_W+1 bits wide; result[DATA_W] is the carry:
  - 0000 add: carry = carry-out.
  - 0001 sub: carry = borrow.
  - 1000 NOR: carry 0.
  - 1100 shift right, zero fill: carry = ACC[0].
  - 1101 shift left: carry = ACC[DATA_W-1].
  - Any other code passes ACC through with carry 0.
- PC priority: `reset` > `LoadPC` > `IncPC` > hold.
  - `LoadPC` with `SelPC`=1 loads zero-extended IR[3:0].
  - `LoadPC` with `SelPC`=0 loads Reg[IR[3:0]][PC_W-1:0]. Jump targets always index IR, never `RegNumber`.
  - Increment wraps from all-ones to 0.
- Register write priority: `DumpAcc` > `LoadReg`. At most one register is written per cycle.
- `Zero_Carry` is the registered ACC carry bit (see Configuration).

## Timing
- Reset values: PC=0, IR=0 (so `Opcode`=0, the NOP), ACC=0, carry=0, all 16 registers=0, `Zero_Carry`=0.
- `reset` asserted mid-instruction overrides every strobe in that cycle.
- All control inputs are sampled at the rising edge. Results are visible one cycle later:
  - `Opcode` is valid the cycle after the `LoadIR` edge.
  - `InstrAddr` changes the cycle after a PC update.
- A register written at edge N reads the new value from N+1 onward. A same-cycle read returns the old value.
- `LoadAcc` combined with `DumpAcc` in the same cycle: the register receives the old ACC, and ACC receives the new value.
- `LoadPC` and `IncPC` asserted together: the load wins.
- No handshakes; the Controller owns sequencing.

## Configuration
- `ACC_ZERO_FLAG_EN`:
  - Defined: `Zero_Carry` = carry | (ACC[DATA_W-1:0] != 0). `Zero_Carry`=0 therefore means ACC is exactly zero with no carry.
  - Undefined: `Zero_Carry` = carry only.
- In both builds the output is combinational from ACC flops and carries no extra latency.

## Structure
- Package `acc_cpu_pkg` holds the ALU op constants (ADD=0000, SUB=0001, NOR=1000, SHR=1100, SHL=1101), the default widths and the register count (16).
- Sub-module `acc_alu`: combinational, with inputs ACC, B and `SelALU`, and a DATA_W+1 result output.
- PC, IR, register file and ACC live in `acc_datapath`.

## Test plan
- Reset, then `InstrData`=8'h4A with `LoadIR` -> next cycle `Opcode`=8'h4A, `InstrAddr`=0.
- Immediate 4'hF with `LoadAcc`, selects 00, then `DumpAcc` with `RegNumber`=3 -> Reg3=8'h0F, `AccOut`=8'h0F.
- ACC=8'hFF, Reg1=8'h01, `DumpReg`, `SelALU`=0000, `SelAcc1`, `LoadAcc` -> `AccOut`=8'h00 and `Zero_Carry`=1 in both builds.
- ACC=8'h00 after reset, no carry -> `Zero_Carry`=0. Then ACC=8'h05 -> `Zero_Carry`=1 only with `ACC_ZERO_FLAG_EN`.
- IR=8'h7C, `LoadPC` and `SelPC`=1 together with `IncPC` -> PC=8'h0C. PC=8'hFF with `IncPC` -> PC=8'h00.
- `reset` asserted in the same cycle as `LoadAcc` and `DumpAcc` -> all state zero the next cycle.
